// File: rtl/rptr_empty.sv
// Async FIFO read-side pointer/empty controller: binary+Gray read pointer, registered empty, level, sticky underflow.
// Latency 1 rclk; pops are ignored while empty. Optional ralmost_empty output with `define RPTR_ALMOST_EMPTY_EN.
module rptr_empty #(
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
`ifdef RPTR_ALMOST_EMPTY_EN
  output logic                ralmost_empty,
`endif
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic              rempty_q, rempty_d;
  logic              runder_q, runder_d;
  logic [ADDRSIZE:0] wbin;
  logic              pop;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  always_comb begin
    pop      = rinc & ~rempty_q;
    rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, pop};
    rptr_d   = (rbin_d >> 1) ^ rbin_d;
    rempty_d = (rptr_d == rq2_wptr);
    rlevel_d = wbin - rbin_d;
    runder_d = runder_q | (rinc & rempty_q);
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rlevel_q <= '0;
      runder_q <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rlevel_q <= rlevel_d;
      runder_q <= runder_d;
    end
  end

`ifdef RPTR_ALMOST_EMPTY_EN
  localparam logic [ADDRSIZE:0] AE_LVL = (ADDRSIZE+1)'(AE_THRESH);
  logic ralmost_q, ralmost_d;

  always_comb begin
    ralmost_d = (rlevel_d <= AE_LVL);
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      ralmost_q <= 1'b1;
    end else begin
      ralmost_q <= ralmost_d;
    end
  end

  assign ralmost_empty = ralmost_q;
`endif

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runder_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Directed bench for rptr_empty: vector table for reset/fill/drain/underflow/full/mid-op reset,
// hand sequences for pointer wrap and (with RPTR_ALMOST_EMPTY_EN) the almost-empty flag.
module tb_rptr_empty;

  logic       rclk = 1'b0;
  logic       rst;
  logic       rinc;
  logic [4:0] rq2_wptr;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [4:0] rlevel;
  logic       runderflow;
`ifdef RPTR_ALMOST_EMPTY_EN
  logic       ralmost_empty;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 rclk = ~rclk;

  rptr_empty #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
    .rclk       (rclk),
    .rst        (rst),
    .rinc       (rinc),
    .rq2_wptr   (rq2_wptr),
`ifdef RPTR_ALMOST_EMPTY_EN
    .ralmost_empty(ralmost_empty),
`endif
    .raddr      (raddr),
    .rptr       (rptr),
    .rempty     (rempty),
    .rlevel     (rlevel),
    .runderflow (runderflow)
  );

  typedef struct {
    logic       rst;
    logic       rinc;
    logic [4:0] wptr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       empty;
    logic [4:0] lvl;
    logic       und;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic drive(input logic r, input logic i, input logic [4:0] w);
    rst      = r;
    rinc     = i;
    rq2_wptr = w;
  endtask

  initial begin
    //           rst   rinc  wptr      raddr  rptr      emp   lvl    und
    tbl[0]  = '{1'b1, 1'b0, 5'b00000, 4'd0, 5'b00000, 1'b1, 5'd0,  1'b0};
    tbl[1]  = '{1'b1, 1'b0, 5'b00000, 4'd0, 5'b00000, 1'b1, 5'd0,  1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'b00010, 4'd0, 5'b00000, 1'b0, 5'd3,  1'b0};
    tbl[3]  = '{1'b0, 1'b1, 5'b00010, 4'd1, 5'b00001, 1'b0, 5'd2,  1'b0};
    tbl[4]  = '{1'b0, 1'b1, 5'b00010, 4'd2, 5'b00011, 1'b0, 5'd1,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 5'd0,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 5'd0,  1'b1};
    tbl[7]  = '{1'b0, 1'b0, 5'b00010, 4'd3, 5'b00010, 1'b1, 5'd0,  1'b1};
    tbl[8]  = '{1'b0, 1'b0, 5'b00110, 4'd3, 5'b00010, 1'b0, 5'd1,  1'b1};
    tbl[9]  = '{1'b0, 1'b1, 5'b00111, 4'd4, 5'b00110, 1'b0, 5'd1,  1'b1};
    tbl[10] = '{1'b1, 1'b0, 5'b00111, 4'd0, 5'b00000, 1'b1, 5'd0,  1'b0};
    tbl[11] = '{1'b0, 1'b0, 5'b11000, 4'd0, 5'b00000, 1'b0, 5'd16, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 5'b11000, 4'd0, 5'b00000, 1'b1, 5'd0,  1'b0};
    tbl[13] = '{1'b0, 1'b0, 5'b00000, 4'd0, 5'b00000, 1'b1, 5'd0,  1'b0};

    drive(1'b1, 1'b0, 5'b00000);
    #2;
    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].rst, tbl[k].rinc, tbl[k].wptr);
      step();
      chk($sformatf("v%0d.raddr", k),  32'(raddr),      32'(tbl[k].raddr));
      chk($sformatf("v%0d.rptr", k),   32'(rptr),       32'(tbl[k].rptr));
      chk($sformatf("v%0d.rempty", k), 32'(rempty),     32'(tbl[k].empty));
      chk($sformatf("v%0d.rlevel", k), 32'(rlevel),     32'(tbl[k].lvl));
      chk($sformatf("v%0d.under", k),  32'(runderflow), 32'(tbl[k].und));
    end

    // Wrap: advance rbin to 30 via legal pops, then pop across 31 -> 0.
    drive(1'b1, 1'b0, 5'b00000);
    step();
    drive(1'b0, 1'b0, 5'b11000);          // wptr bin 16
    step();
    rinc = 1'b1;
    for (int k = 0; k < 16; k++) step();
    rinc = 1'b0;
    chk("wrap.rbin16.rptr", 32'(rptr), 32'(5'b11000));
    chk("wrap.rbin16.empty", 32'(rempty), 32'(1'b1));
    rq2_wptr = 5'b10001;                  // wptr bin 30
    step();
    rinc = 1'b1;
    for (int k = 0; k < 14; k++) step();
    rinc = 1'b0;
    chk("wrap.rbin30.rptr", 32'(rptr), 32'(5'b10001));
    chk("wrap.rbin30.raddr", 32'(raddr), 32'(4'd14));
    rq2_wptr = 5'b00011;                  // wptr bin 2
    step();
    chk("wrap.lvl4", 32'(rlevel), 32'(5'd4));
    chk("wrap.nonempty", 32'(rempty), 32'(1'b0));
    rinc = 1'b1;
    step();
    chk("wrap.pop1.rptr", 32'(rptr), 32'(5'b10000));
    chk("wrap.pop1.lvl", 32'(rlevel), 32'(5'd3));
    step();
    rinc = 1'b0;
    chk("wrap.pop2.rptr", 32'(rptr), 32'(5'b00000));
    chk("wrap.pop2.raddr", 32'(raddr), 32'(4'd0));
    chk("wrap.pop2.lvl", 32'(rlevel), 32'(5'd2));
    chk("wrap.pop2.empty", 32'(rempty), 32'(1'b0));
    chk("wrap.no_under", 32'(runderflow), 32'(1'b0));

`ifdef RPTR_ALMOST_EMPTY_EN
    drive(1'b1, 1'b0, 5'b00000);
    step();
    chk("ae.reset", 32'(ralmost_empty), 32'(1'b1));
    drive(1'b0, 1'b0, 5'b00010);          // level 3
    step();
    chk("ae.lvl3", 32'(ralmost_empty), 32'(1'b0));
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    chk("ae.lvl2.level", 32'(rlevel), 32'(5'd2));
    chk("ae.lvl2", 32'(ralmost_empty), 32'(1'b1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rptr_empty.md
Name: rptr_empty

Overview:
Read-side pointer and empty-flag controller for the async FIFO; the reader counterpart to the write-side logic.
- Runs entirely in the read clock domain.
- Consumes the write pointer after it has been synchronized into rclk as Gray code.
- Produces the RAM read address, the Gray read pointer (sent to the write domain for synchronization), a registered empty flag, a fill level and a sticky underflow error.

Parameters:
ADDRSIZE, 4, FIFO depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits (extra wrap bit).
AE_THRESH, 2, almost-empty threshold in entries (used only with RPTR_ALMOST_EMPTY_EN).

Ports:
rclk  input  1  read-domain clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset, sampled on rising rclk.
rinc  input  1  read request; a pop occurs when rinc=1 and rempty=0.
rq2_wptr  input  ADDRSIZE+1  write pointer, Gray code, already 2-flop synchronized into rclk.
raddr  output  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0].
rptr  output  ADDRSIZE+1  registered Gray read pointer, to the write-domain synchronizer.
rempty  output  1  registered empty flag.
rlevel  output  ADDRSIZE+1  registered occupancy as seen from the read side, 0..2^ADDRSIZE.
runderflow  output  1  sticky error: set when rinc=1 while rempty=1.
Clocking/reset (decided): one clock, rclk; reset rst is synchronous and active-high.

Behaviour:
- State: rbin, a binary read counter of ADDRSIZE+1 bits. rptr, rempty, rlevel and runderflow are registers.
- Reset (rst=1 at an edge): rbin=0, rptr=0, raddr=0, rempty=1, rlevel=0, runderflow=0.
  - rst has priority over rinc.
  - Mid-operation reset discards any pending pop.
- Combinational next-state values:
  - pop = rinc & ~rempty.
  - rbinnext = rbin + pop, modulo 2^(ADDRSIZE+1).
  - rgraynext = (rbinnext >> 1) ^ rbinnext.
  - wbin = Gray-to-binary of rq2_wptr (MSB first, prefix XOR).
- Each edge (no rst):
  - rbin <= rbinnext; rptr <= rgraynext.
  - rempty <= (rgraynext == rq2_wptr).
  - rlevel <= (wbin - rbinnext) mod 2^(ADDRSIZE+1).
- Latency and data path:
  - raddr changes one cycle after a pop; RAM data for the new address is the RAM's concern.
  - rempty and rlevel reflect rq2_wptr as sampled in the same cycle, i.e. one rclk later.
- Empty behaviour:
  - rempty deasserts one cycle after rq2_wptr moves away from rptr.
  - rempty asserts in the same edge as the pop that consumes the last visible entry.
  - Empty is pessimistic: the write pointer is stale by the synchronizer delay; this is acceptable.
- Wrap-around: rbin rolls 2^(ADDRSIZE+1)-1 -> 0. The Gray code changes exactly one bit per pop, including at wrap. rlevel uses modular subtraction, so it is correct across the wrap.
- Full level: rlevel = 2^ADDRSIZE when the MSBs differ and the lower address bits are equal. rlevel never exceeds 2^ADDRSIZE.
- Underflow: rinc=1 while rempty=1 leaves rbin and rptr unchanged and sets runderflow at the next edge. runderflow holds until rst.
- Simultaneous rinc and rq2_wptr change: the pop uses the registered rempty; the new empty value uses the new rq2_wptr.

Optional Feature:
RPTR_ALMOST_EMPTY_EN:
- Defined: adds output port ralmost_empty (1 bit), registered.
  - Next value = (levelnext <= AE_THRESH), where levelnext = (wbin - rbinnext) mod 2^(ADDRSIZE+1).
  - Reset value 1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: rst=1 for 2 cycles, rq2_wptr=0 -> rptr=0, raddr=0, rempty=1, rlevel=0, runderflow=0.
2. Fill/drain: set rq2_wptr=5'b00010 (bin 3), rinc=0 -> next cycle rempty=0, rlevel=3. Then rinc=1 for 3 cycles -> raddr 1,2,3; rptr 00001,00011,00010; rlevel 2,1,0; rempty=1 after the third pop.
3. Underflow: with rempty=1, pulse rinc for 1 cycle -> rptr unchanged, runderflow=1 next cycle and stays 1 until rst.
4. Wrap: set rbin=30 (rptr=5'b10001), rq2_wptr=5'b00011 (bin 2) -> rlevel=4. Pop 2 -> rbin=0, raddr=0, rptr=00000, rlevel=2.
5. Full and mid-op reset: rbin=0, rq2_wptr=5'b11000 (bin 16) -> rlevel=16, rempty=0. Then assert rst together with rinc -> next edge all outputs at reset values, no pop.
6. With RPTR_ALMOST_EMPTY_EN, AE_THRESH=2, level 3 -> ralmost_empty=0. One pop -> level 2, ralmost_empty=1.
